if_stage: RTL and testbench

Instruction-fetch stage sitting directly upstream of the decode stage. Owns the program counter and issues one-outstanding fetch requests to an instruction memory with req/gnt/rvalid handshaking. Holds each fetched instruction and its PC in a single-entry output buffer until decode accepts it. Applies branch/jump redirects from execute, and squashes any fetch that is in flight or buffered when a redirect arrives.

---
 rtl/if_stage_pkg.sv | 31 +++
 rtl/if_stage_fetch_buffer.sv | 49 ++++
 rtl/if_stage.sv | 150 +++++++++++++++
 tb/tb_if_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_stage_pkg
//   Shared definitions for the instruction-fetch stage: data widths, the
//   reset PC and NOP defaults, the fetch FSM state encoding and a small
//   PC-alignment helper.
// ----------------------------------------------------------------------------
package if_stage_pkg;

   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] NOP_INSTR_C      = 32'h0000_0013; // addi x0,x0,0

   // Fetch FSM encoding. IDLE waits for buffer space, REQ holds imem_req until
   // gnt, WAIT waits for the single outstanding response.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_REQ  = ST_REQ,
      S_WAIT = ST_WAIT
   } fetch_state_e;

   // Force a byte address onto a word boundary.
   function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
      return {addr[INSTR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_stage_fetch_buffer.sv
// ----------------------------------------------------------------------------
// if_fetch_buffer
//   Single-entry holding register between fetch and decode.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     load                capture load_instr/load_pc and mark the entry valid
//     load_instr, load_pc data and PC written on load
//     drain               decode took the entry this cycle
//     flush               drop the entry (redirect); wins over load and drain
//     valid, instr,       current entry contents
//     instr_pc
// ----------------------------------------------------------------------------
module if_fetch_buffer
   import if_stage_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_C
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [INSTR_W-1:0] load_instr,
   input  logic [INSTR_W-1:0] load_pc,
   input  logic               drain,
   input  logic               flush,
   output logic               valid,
   output logic [INSTR_W-1:0] instr,
   output logic [INSTR_W-1:0] instr_pc
);

   // Only the valid bit is cleared on flush/drain; data is left in place
   // because nothing downstream looks at it while valid is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid    <= 1'b0;
         instr    <= NOP_INSTR;
         instr_pc <= RESET_PC;
      end else if (flush) begin
         valid    <= 1'b0;
      end else if (load) begin
         valid    <= 1'b1;
         instr    <= load_instr;
         instr_pc <= load_pc;
      end else if (drain) begin
         valid    <= 1'b0;
      end
   end

endmodule

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage. Owns the PC, issues one outstanding fetch at a
//   time to instruction memory and parks the result in a one-entry buffer
//   until decode takes it. Redirects from execute replace the PC and squash
//   whatever is buffered or in flight.
//
//   Handshakes:
//     imem_req/imem_gnt : request is accepted on a cycle with both high;
//                         imem_addr is held stable meanwhile unless a
//                         redirect arrives.
//     imem_rvalid       : one response per accepted request, only honoured
//                         in WAIT.
//     instr_valid/id_ready : instruction transfers on a cycle with both high.
//
//   Ports:
//     clk, rst                       clock, asynchronous active-high reset
//     redirect_valid, redirect_pc    PC change request from execute
//     imem_req, imem_addr            fetch request and word address
//     imem_gnt, imem_rvalid,         memory accept, response valid and data
//     imem_rdata
//     instr_valid, instr, instr_pc   buffered instruction to decode
//     id_ready                       decode accepts the instruction
//     misalign                       one-cycle pulse on a misaligned redirect
// ----------------------------------------------------------------------------
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_C
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_valid,
   input  logic [INSTR_W-1:0] redirect_pc,
   output logic               imem_req,
   output logic [INSTR_W-1:0] imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [INSTR_W-1:0] instr_pc,
   input  logic               id_ready,
   output logic               misalign
);

   fetch_state_e       state_q, state_d;
   logic [INSTR_W-1:0] pc_q, pc_d;
   logic               kill_q, kill_d;
   logic               misalign_d;
   logic               buf_load;
   logic               transfer;
   logic               buf_free;

   assign transfer  = instr_valid & id_ready;
   assign buf_free  = ~instr_valid | transfer;

   assign imem_req  = (state_q == S_REQ);
   assign imem_addr = pc_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      kill_d     = kill_q;
      misalign_d = 1'b0;
      buf_load   = 1'b0;

      if (redirect_valid) begin
         pc_d       = word_align(redirect_pc);
         misalign_d = |redirect_pc[1:0];
         unique case (state_q)
            S_WAIT: begin
               if (imem_rvalid) begin
                  // Response lands this cycle: drop it and refetch. Any
                  // pending orphan has now returned, so kill is clear.
                  state_d = S_REQ;
                  kill_d  = 1'b0;
               end else begin
                  // The response is still out there for the old address.
                  kill_d  = 1'b1;
               end
            end
            S_REQ: begin
               if (imem_gnt) begin
                  // Memory took the old address; its response must be eaten.
                  state_d = S_WAIT;
                  kill_d  = 1'b1;
               end
            end
            default: state_d = S_REQ;
         endcase
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (buf_free) state_d = S_REQ;
            end
            S_REQ: begin
               if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (kill_q) begin
                     kill_d  = 1'b0;
                     state_d = S_REQ;
                  end else begin
                     // The buffer was free when REQ was entered, so this
                     // load never overwrites a pending instruction.
                     buf_load = 1'b1;
                     pc_d     = pc_q + 32'd4;
                     state_d  = S_IDLE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         kill_q   <= 1'b0;
         misalign <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         kill_q   <= kill_d;
         misalign <= misalign_d;
      end
   end

   if_fetch_buffer #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP_INSTR)
   ) u_fetch_buffer (
      .clk        (clk),
      .rst        (rst),
      .load       (buf_load),
      .load_instr (imem_rdata),
      .load_pc    (pc_q),
      .drain      (transfer),
      .flush      (redirect_valid),
      .valid      (instr_valid),
      .instr      (instr),
      .instr_pc   (instr_pc)
   );

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        id_ready;
   logic        misalign;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];

   if_stage dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .id_ready       (id_ready),
      .misalign       (misalign)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // checking task
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // driver: advance one clock, land 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect_to(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
   endtask

   // scoreboard: every instruction decode actually takes must be the next one expected
   always @(negedge clk) begin
      if (!rst && instr_valid && id_ready && !redirect_valid) begin
         if (exp_q.size() == 0)
            check("sb_extra_transfer", instr, 32'hxxxx_xxxx);
         else
            check("sb_instr", instr, exp_q.pop_front());
      end
   end

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'h0;
      id_ready       = 1'b0;

      // reset state, before any clock edge
      #1;
      check("rst_req",      {31'b0, imem_req},    32'h0);
      check("rst_addr",     imem_addr,            32'h0);
      check("rst_valid",    {31'b0, instr_valid}, 32'h0);
      check("rst_instr",    instr,                32'h0000_0013);
      check("rst_instr_pc", instr_pc,             32'h0);
      check("rst_misalign", {31'b0, misalign},    32'h0);
      tick();
      tick();

      // 1: first fetch, gnt same cycle, rvalid one cycle later
      rst = 1'b0;
      tick();
      check("t1_req",  {31'b0, imem_req}, 32'h1);
      check("t1_addr", imem_addr,         32'h0);
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      check("t1_req_wait", {31'b0, imem_req}, 32'h0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0050_0093;
      tick();
      imem_rvalid = 1'b0;
      check("t1_valid",    {31'b0, instr_valid}, 32'h1);
      check("t1_instr",    instr,                32'h0050_0093);
      check("t1_instr_pc", instr_pc,             32'h0);
      exp_q.push_back(32'h0050_0093);

      // 2: decode stalls for 5 cycles
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t2_hold_valid", {31'b0, instr_valid}, 32'h1);
         check("t2_hold_instr", instr,                32'h0050_0093);
         check("t2_hold_pc",    instr_pc,             32'h0);
         check("t2_hold_req",   {31'b0, imem_req},    32'h0);
      end
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      check("t2_req",   {31'b0, imem_req},    32'h1);
      check("t2_addr",  imem_addr,            32'h4);
      check("t2_valid", {31'b0, instr_valid}, 32'h0);

      // 3: redirect while waiting; orphan response must be eaten
      id_ready = 1'b1;
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      redirect_to(32'h100);
      tick();
      redirect_valid = 1'b0;
      check("t3_valid_a", {31'b0, instr_valid}, 32'h0);
      check("t3_req_a",   {31'b0, imem_req},    32'h0);
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      tick();
      imem_rvalid = 1'b0;
      check("t3_orphan_valid", {31'b0, instr_valid}, 32'h0);
      check("t3_req",          {31'b0, imem_req},    32'h1);
      check("t3_addr",         imem_addr,            32'h100);
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h1111_1111;
      tick();
      imem_rvalid = 1'b0;
      check("t3_valid",    {31'b0, instr_valid}, 32'h1);
      check("t3_instr",    instr,                32'h1111_1111);
      check("t3_instr_pc", instr_pc,             32'h100);
      exp_q.push_back(32'h1111_1111);
      tick();
      check("t3_next_addr", imem_addr,         32'h104);
      check("t3_next_req",  {31'b0, imem_req}, 32'h1);

      // 4a: redirect in the same cycle as rvalid
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h2222_2222;
      redirect_to(32'h200);
      tick();
      imem_rvalid    = 1'b0;
      redirect_valid = 1'b0;
      check("t4a_valid", {31'b0, instr_valid}, 32'h0);
      check("t4a_req",   {31'b0, imem_req},    32'h1);
      check("t4a_addr",  imem_addr,            32'h200);
      // kill must not be set: the very next response is delivered
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h3333_3333;
      tick();
      imem_rvalid = 1'b0;
      check("t4a_nokill_valid", {31'b0, instr_valid}, 32'h1);
      check("t4a_nokill_instr", instr,                32'h3333_3333);
      check("t4a_nokill_pc",    instr_pc,             32'h200);

      // 4b: redirect with buffer valid and decode ready drops the entry
      redirect_to(32'h200);
      tick();
      redirect_valid = 1'b0;
      check("t4b_valid", {31'b0, instr_valid}, 32'h0);
      check("t4b_req",   {31'b0, imem_req},    32'h1);
      check("t4b_addr",  imem_addr,            32'h200);

      // 4c: redirect on the gnt cycle; response for old address is eaten
      imem_gnt = 1'b1;
      redirect_to(32'h300);
      tick();
      imem_gnt       = 1'b0;
      redirect_valid = 1'b0;
      check("t4c_req_wait", {31'b0, imem_req}, 32'h0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h4444_4444;
      tick();
      imem_rvalid = 1'b0;
      check("t4c_valid", {31'b0, instr_valid}, 32'h0);
      check("t4c_req",   {31'b0, imem_req},    32'h1);
      check("t4c_addr",  imem_addr,            32'h300);

      // 5: misaligned redirect
      check("t5_misalign_pre", {31'b0, misalign}, 32'h0);
      redirect_to(32'h102);
      tick();
      redirect_valid = 1'b0;
      check("t5_misalign", {31'b0, misalign}, 32'h1);
      check("t5_addr",     imem_addr,         32'h100);
      check("t5_req",      {31'b0, imem_req}, 32'h1);
      tick();
      check("t5_misalign_drop", {31'b0, misalign}, 32'h0);
      check("t5_addr_hold",     imem_addr,         32'h100);

      // 6: asynchronous reset mid-WAIT, checked before any clock edge
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      check("t6_req_wait", {31'b0, imem_req}, 32'h0);
      #2;
      rst = 1'b1;
      #1;
      check("t6_req",      {31'b0, imem_req},    32'h0);
      check("t6_valid",    {31'b0, instr_valid}, 32'h0);
      check("t6_addr",     imem_addr,            32'h0);
      check("t6_instr",    instr,                32'h0000_0013);
      check("t6_instr_pc", instr_pc,             32'h0);
      tick();
      rst         = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h5555_5555;
      tick();
      check("t6_late_valid", {31'b0, instr_valid}, 32'h0);
      check("t6_late_req",   {31'b0, imem_req},    32'h1);
      check("t6_late_addr",  imem_addr,            32'h0);
      tick();
      imem_rvalid = 1'b0;
      check("t6_late_valid2", {31'b0, instr_valid}, 32'h0);
      check("t6_late_req2",   {31'b0, imem_req},    32'h1);

      // PC wrap at the top of the address space
      redirect_to(32'hFFFF_FFFC);
      tick();
      redirect_valid = 1'b0;
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h6666_6666;
      tick();
      imem_rvalid = 1'b0;
      check("wrap_valid",    {31'b0, instr_valid}, 32'h1);
      check("wrap_instr_pc", instr_pc,             32'hFFFF_FFFC);
      exp_q.push_back(32'h6666_6666);
      tick();
      check("wrap_next_addr", imem_addr,         32'h0);
      check("wrap_next_req",  {31'b0, imem_req}, 32'h1);

      tick();
      check("sb_drained", exp_q.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
